// File: rtl/fetch_pkg.sv
// Shared types and constants for the buffered fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam int unsigned PC_STEP    = 4;

  // One fetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; used for the fetch queue and the request-PC tag FIFO.
module fetch_fifo #(
  parameter type         T     = logic [31:0],
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  T                           din,
  input  logic                       pop,
  output T                           dout,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Pointer increment that also works for non-power-of-2 depths.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Status flags and head-of-queue data (zero while empty).
  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    count   = count_q;
    do_push = push && !full;
    do_pop  = pop && !empty;
    dout    = empty ? '0 : mem_q[rd_ptr_q];
  end

  // Next-state for pointers and occupancy; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; data needs no reset because dout is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

  // Upstream credit logic guarantees no overflow or underflow.
  a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(push && full && !flush));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && empty && !flush));

endmodule

// File: rtl/fetch_buffered.sv
// Decoupled IF stage: credit-based icache requests, in-order response buffering, redirect squash.
module fetch_buffered
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN      = FETCH_XLEN,
  parameter int unsigned     DEPTH     = 4,
  parameter int unsigned     MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            icache_req_valid,
  input  logic            icache_req_ready,
  output logic [XLEN-1:0] icache_req_addr,
  input  logic            icache_resp_valid,
  input  logic [XLEN-1:0] icache_resp_data,
  output logic            decode_valid,
  input  logic            decode_ready,
  output logic [XLEN-1:0] decode_instr,
  output logic [XLEN-1:0] decode_pc
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [OW-1:0]   drop_q, drop_d;

  logic            req_fire, resp_keep, dec_pop;
  fetch_entry_t    q_din, q_dout;
  logic            q_full, q_empty;
  logic [CW-1:0]   q_count;
  logic [XLEN-1:0] tag_dout;
  logic            tag_full, tag_empty;
  logic [OW-1:0]   tag_count;

  // Request credit: every accepted request must own a queue slot.
  always_comb begin
    icache_req_valid = !reset && !redirect_valid && (outst_q < OW'(MAX_OUTST)) &&
                       ((SW'(q_count) + SW'(outst_q)) < SW'(DEPTH));
    icache_req_addr  = pc_q;
    req_fire         = icache_req_valid && icache_req_ready;
    resp_keep        = icache_resp_valid && !redirect_valid && (drop_q == '0);
    dec_pop          = decode_valid && decode_ready && !redirect_valid;
    q_din            = '{pc: tag_dout, instr: icache_resp_data};
    decode_valid     = !q_empty;
    decode_pc        = q_dout.pc;
    decode_instr     = q_dout.instr;
  end

  // Next PC and outstanding/drop counters; a redirect converts all outstanding into drops.
  always_comb begin
    pc_d    = pc_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
      outst_d = outst_q - OW'(icache_resp_valid);
      drop_d  = outst_q - OW'(icache_resp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(PC_STEP);
      outst_d = outst_q + OW'(req_fire) - OW'(icache_resp_valid);
      if (icache_resp_valid && (drop_q != '0)) drop_d = drop_q - OW'(1);
    end
  end

  // PC and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  // Fetch queue feeding decode.
  fetch_fifo #(.T(fetch_entry_t), .DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (resp_keep),
    .din   (q_din),
    .pop   (dec_pop),
    .dout  (q_dout),
    .flush (redirect_valid),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // In-order PCs of live (not squashed) requests, paired with responses.
  fetch_fifo #(.T(logic [XLEN-1:0]), .DEPTH(MAX_OUTST)) u_tags (
    .clk   (clk),
    .reset (reset),
    .push  (req_fire),
    .din   (pc_q),
    .pop   (resp_keep),
    .dout  (tag_dout),
    .flush (redirect_valid),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  // Live tags plus pending drops always account for every outstanding request.
  a_tag_balance: assert property (@(posedge clk) disable iff (reset)
                   (SW'(tag_count) + SW'(drop_q)) == SW'(outst_q));
  a_tag_room:    assert property (@(posedge clk) disable iff (reset) !(req_fire && tag_full));
  a_tag_avail:   assert property (@(posedge clk) disable iff (reset) !(resp_keep && tag_empty));
  a_queue_room:  assert property (@(posedge clk) disable iff (reset) !(resp_keep && q_full));

endmodule

// File: tb/tb_fetch_buffered.sv
// Randomized bench for fetch_buffered with an icache model and a transaction-level reference queue.
module tb_fetch_buffered;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic            clk = 1'b0;
  logic            reset;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            icache_req_valid;
  logic            icache_req_ready;
  logic [XLEN-1:0] icache_req_addr;
  logic            icache_resp_valid;
  logic [XLEN-1:0] icache_resp_data;
  logic            decode_valid;
  logic            decode_ready;
  logic [XLEN-1:0] decode_instr;
  logic [XLEN-1:0] decode_pc;

  fetch_buffered #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .reset             (reset),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .icache_req_valid  (icache_req_valid),
    .icache_req_ready  (icache_req_ready),
    .icache_req_addr   (icache_req_addr),
    .icache_resp_valid (icache_resp_valid),
    .icache_resp_data  (icache_resp_data),
    .decode_valid      (decode_valid),
    .decode_ready      (decode_ready),
    .decode_instr      (decode_instr),
    .decode_pc         (decode_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t        pend[$];     // requests the cache has accepted, in order
  ent_t        q[$];        // expected contents of the fetch queue
  logic [31:0] popped[$];   // DUT decode_pc values observed on each pop
  logic [31:0] m_pc;
  logic [31:0] last_fire_addr;
  int          epoch, cyc, n_pop;
  int          n_tests, n_fail;
  int          rdy_pct, dec_pct, lat_min, lat_max;
  bit          redir_now;
  logic [31:0] redir_tgt;

  // Instruction word the cache returns for an address.
  function automatic logic [31:0] ifn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive, sample/check mid-cycle, advance, update the model.
  task automatic cycle();
    bit          resp_now, exp_rv, exp_dv, fire, pop;
    int          due;
    req_t        r;
    redirect_valid    = redir_now;
    redirect_pc       = redir_tgt;
    icache_req_ready  = (int'($urandom_range(99)) < rdy_pct);
    decode_ready      = (int'($urandom_range(99)) < dec_pct);
    resp_now          = !reset && (pend.size() > 0) && (pend[0].due <= cyc);
    icache_resp_valid = resp_now;
    icache_resp_data  = resp_now ? ifn(pend[0].addr) : $urandom;
    #1;
    exp_rv = !reset && !redir_now && (pend.size() < MAX_OUTST) &&
             ((q.size() + pend.size()) < DEPTH);
    exp_dv = (q.size() != 0);
    check("req_valid", 32'(icache_req_valid), 32'(exp_rv));
    if (!reset) check("req_addr", icache_req_addr, m_pc);
    check("dec_valid", 32'(decode_valid), 32'(exp_dv));
    if (exp_dv) begin
      check("dec_pc", decode_pc, q[0].pc);
      check("dec_instr", decode_instr, q[0].instr);
    end
    fire = exp_rv && icache_req_ready;
    pop  = exp_dv && decode_ready && !redir_now && !reset;
    if (fire) last_fire_addr = icache_req_addr;
    if (pop) begin popped.push_back(decode_pc); n_pop++; end
    @(posedge clk);
    if (reset) begin
      pend.delete(); q.delete(); m_pc = RESET_PC; epoch++;
    end else begin
      if (pop) void'(q.pop_front());
      if (resp_now) begin
        r = pend.pop_front();
        if (!redir_now && r.epoch == epoch) q.push_back('{r.addr, ifn(r.addr)});
      end
      if (fire) begin
        due = cyc + int'($urandom_range(lat_max, lat_min));
        if (pend.size() > 0 && due <= pend[$].due) due = pend[$].due + 1;
        pend.push_back('{m_pc, epoch, due});
        m_pc = m_pc + 32'd4;
      end
      if (redir_now) begin
        epoch++; q.delete(); m_pc = redir_tgt & 32'hFFFF_FFFC;
      end
    end
    if (q.size() > DEPTH) check("model_overflow", 32'(q.size()), 32'(DEPTH));
    cyc++;
    redir_now = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
  endtask

  task automatic knobs(input int rp, input int dp, input int lmin, input int lmax);
    rdy_pct = rp; dec_pct = dp; lat_min = lmin; lat_max = lmax;
  endtask

  initial begin
    int base, k;
    n_tests = 0; n_fail = 0; cyc = 0; epoch = 0; n_pop = 0;
    redir_now = 1'b0; redir_tgt = '0; m_pc = RESET_PC; last_fire_addr = '0;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    icache_req_ready = 1'b0; icache_resp_valid = 1'b0; icache_resp_data = '0; decode_ready = 1'b0;
    knobs(100, 100, 1, 1);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    cycle();
    check("rst_dec_valid", 32'(decode_valid), 32'd0);
    check("rst_dec_pc", decode_pc, 32'd0);
    check("rst_dec_instr", decode_instr, 32'd0);
    reset = 1'b0;
    #1;
    check("first_req_valid", 32'(icache_req_valid), 32'd1);
    check("first_req_addr", icache_req_addr, RESET_PC);

    // 1: streaming at one instruction per cycle
    popped.delete();
    repeat (10) cycle();
    check("t1_first_pc", popped[0], 32'd0);
    base = n_pop;
    repeat (6) cycle();
    check("t1_rate", 32'(n_pop - base), 32'd6);

    // 2: decode stalled, queue fills to DEPTH, then drains in order
    do_reset();
    knobs(100, 0, 1, 1);
    popped.delete();
    repeat (10) cycle();
    check("t2_stall_req", 32'(icache_req_valid), 32'd0);
    check("t2_full_valid", 32'(decode_valid), 32'd1);
    knobs(100, 100, 1, 1);
    repeat (5) cycle();
    for (int i = 0; i < 4; i++) check("t2_drain_pc", popped[i], 32'(4 * i));
    check("t2_resume_pc", popped[4], 32'd16);

    // 3: redirect with two requests in flight
    do_reset();
    knobs(100, 100, 4, 4);
    k = 0;
    while (pend.size() < 2 && k < 20) begin cycle(); k++; end
    check("t3_two_outst", 32'(pend.size()), 32'd2);
    redir_now = 1'b1; redir_tgt = 32'h103;
    popped.delete();
    cycle();
    check("t3_req_addr", icache_req_addr, 32'h100);
    k = 0;
    while (popped.size() == 0 && k < 40) begin cycle(); k++; end
    check("t3_first_pop", (popped.size() > 0) ? popped[0] : 32'hDEAD_BEEF, 32'h100);

    // 4: redirect coinciding with the only outstanding response
    do_reset();
    knobs(100, 100, 1, 1);
    k = 0;
    while (!(pend.size() == 1 && pend[0].due <= cyc) && k < 20) begin cycle(); k++; end
    check("t4_setup", 32'(pend.size()), 32'd1);
    redir_now = 1'b1; redir_tgt = 32'h200;
    knobs(0, 100, 1, 1);
    cycle();
    repeat (3) cycle();
    check("t4_no_spurious", 32'(decode_valid), 32'd0);
    check("t4_no_outst", 32'(pend.size()), 32'd0);

    // 5: held request address, then PC wrap
    begin
      logic [31:0] a0;
      a0 = icache_req_addr;
      repeat (3) begin cycle(); check("t5_addr_hold", icache_req_addr, a0); end
    end
    knobs(100, 100, 1, 1);
    redir_now = 1'b1; redir_tgt = 32'hFFFF_FFFE;
    cycle();
    k = 0;
    while (last_fire_addr != 32'hFFFF_FFFC && k < 20) begin cycle(); k++; end
    check("t5_wrap", icache_req_addr, 32'h0);

    // 6: reset while busy
    knobs(100, 0, 3, 3);
    repeat (8) cycle();
    reset = 1'b1;
    cycle();
    check("t6_dec_valid", 32'(decode_valid), 32'd0);
    cycle();
    reset = 1'b0;
    knobs(100, 100, 1, 3);
    #1;
    check("t6_req_valid", 32'(icache_req_valid), 32'd1);
    check("t6_req_addr", icache_req_addr, RESET_PC);

    // Random traffic with redirects and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0)
        knobs(int'($urandom_range(100, 20)), int'($urandom_range(100, 10)),
              int'($urandom_range(2, 1)), int'($urandom_range(6, 2)));
      if ($urandom_range(99) < 3) begin redir_now = 1'b1; redir_tgt = $urandom; end
      reset = ($urandom_range(999) < 3);
      cycle();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
